mole_game_ctrl: RTL and testbench
=================================

Name: mole_game_ctrl

Overview:
Parametrised multi-target reaction-game controller. It lights one of NUM_CH targets at a time, detects debounced button hits on the lit channel, and accumulates hits into a pending score delta. The delta is injected into the processor register file on cycles when the CPU is not writing. It also drives a one-hot score display from the stored score. It sits between board I/O and the regfile write-port mux at top level.

Parameters:
NUM_CH, 4, number of target LED/button pairs (>=2)
ON_CYCLES, 100000000, cycles a target stays lit without a hit
OFF_CYCLES, 200000000, dark gap between targets
DEBOUNCE_CYCLES, 1000000, stable-sample count before a button change is accepted (>=1)
PEND_W, 3, width of pending score delta (saturating)
SCORE_REG, 30, regfile index written by injection
LED_N, 6, score display LED count
LFSR_SEED, 16'hACE1, nonzero reset seed of channel-select LFSR

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
btn  in  NUM_CH  raw buttons, active-low (0 = pressed), asynchronous
target  out  NUM_CH  target LEDs, at most one bit set
cpu_we  in  1  CPU regfile write enable this cycle
inj_we  out  1  injected write enable (top muxes inj over CPU when high)
inj_rd  out  5  constant SCORE_REG
inj_data  out  32  zero-extended pending delta
score_in  in  32  stored score from regfile
score_led  out  LED_N  one-hot of score_in % LED_N
hit_pulse  out  1  one-cycle pulse per valid hit
miss_pulse  out  1  one-cycle pulse on ON timeout or wrong-button press

Behaviour:
- Reset (async, any state): FSM=OFF, counters 0, target=0, inj_we=0, pending=0, hit_pulse=miss_pulse=0, score_led=0, LFSR=LFSR_SEED, debounced btn=all 1, prev_ch=0.
- Input path per channel: 2-flop synchroniser, then debouncer. The debounced value takes the synced value after that value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Press event = debounced 1->0. A clean low step on btn yields a press event exactly DEBOUNCE_CYCLES+3 cycles after the first sampling edge. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
- FSM states: OFF, ON.
- OFF: counter runs to OFF_CYCLES-1. Next cycle the FSM enters ON with ch = lfsr % NUM_CH; if ch==prev_ch, then ch=(ch+1)%NUM_CH. target registered = one-hot(ch).
- ON: target held; counter runs.
  - Press on ch: hit_pulse, pending+1, target=0, go OFF (counter=0). Press events on the lit channel in OFF are ignored.
  - Press on any other channel: miss_pulse, remain ON.
  - Counter reaches ON_CYCLES-1 with no hit: miss_pulse, go OFF.
  - Hit and timeout in the same cycle: hit wins.
  - Multiple press events in one cycle: any hit on ch is a hit; no miss is also reported.
- Pending: saturates at 2^PEND_W-1; increments beyond that are dropped while hit_pulse still fires.
- Injection: inj_we is combinational = (!cpu_we && pending!=0 && !inj_cooldown).
  - When inj_we=1 at a clock edge, pending clears, or becomes 1 if a hit lands that same cycle. inj_cooldown is set for one cycle, so at most one write per two cycles.
  - cpu_we=1 defers injection indefinitely with pending preserved.
- score_led: registered one cycle, one-hot(score_in % LED_N); exactly one bit set after the first post-reset edge.

Decomposition:
- Package mole_game_pkg: FSM state enum (ST_OFF, ST_ON), LFSR tap mask, default timing constants.
- Sub-module btn_debounce (synchroniser + debouncer, one instance per channel via generate).

Test Plan:
All with NUM_CH=4, ON_CYCLES=20, OFF_CYCLES=10, DEBOUNCE_CYCLES=3, PEND_W=3, LED_N=6.
1. Reset then idle, no buttons -> target=0 for 10 cycles, then a one-hot target for 20 cycles, miss_pulse once, then dark. Consecutive targets are never the same channel.
2. Press lit channel cleanly 5 cycles into ON, cpu_we=0 -> hit_pulse at press+6, target=0 next cycle. Next cycle inj_we=1, inj_rd=30, inj_data=1; pending then 0.
3. Hold cpu_we=1, score 9 hits -> pending saturates at 7 and hit_pulse fires 9 times. Drop cpu_we -> single write with inj_data=7.
4. 2-cycle low glitch on lit button -> no hit_pulse, target stays lit until timeout miss.
5. Wrong button press during ON -> miss_pulse, target unchanged, then a correct hit is still accepted.
6. Assert reset mid-ON with pending=2 -> immediately target=0, inj_we=0, pending=0. score_in=13 -> score_led=6'b000010 one cycle later.

Source files
------------

// File: rtl/mole_game_pkg.sv
// Shared definitions for the reaction-game controller.
//   state_t     : target FSM states (dark gap / target lit)
//   LFSR_TAPS   : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   DEF_*       : default board timing at the production clock rate
//   lfsr_next() : one LFSR step
package mole_game_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_ON_CYCLES       = 100000000;
    localparam int DEF_OFF_CYCLES      = 200000000;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser and debouncer for one active-low push button.
//   clk, reset : system clock, asynchronous active-high reset
//   btn        : raw asynchronous button level (0 = pressed)
//   press      : one-cycle pulse when the debounced level falls 1->0
// A clean low step sampled first at edge E0 produces press in the cycle
// following edge E0+DEBOUNCE_CYCLES+3.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // Idle level of an unpressed button is 1, so every stage resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            // Any sample that agrees with the debounced level restarts the run.
            if (sync2 != deb) begin
                if (cnt == CNT_LAST) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Reaction-game controller: lights one of NUM_CH targets at a time, scores
// debounced hits into a saturating pending delta and injects that delta into
// the register file on cycles the CPU leaves the write port idle.
//   clk, reset   : system clock, asynchronous active-high reset
//   btn          : raw active-low buttons, one per target
//   target       : target LEDs, at most one set
//   cpu_we       : CPU owns the regfile write port this cycle
//   inj_we       : injection write enable (combinational)
//   inj_rd       : destination register index (SCORE_REG)
//   inj_data     : zero-extended pending delta
//   score_in     : stored score read back from the regfile
//   score_led    : registered one-hot of score_in % LED_N
//   hit_pulse    : one cycle per accepted hit
//   miss_pulse   : one cycle per timeout or wrong-button press
module mole_game_ctrl
    import mole_game_pkg::*;
#(
    parameter int          NUM_CH          = 4,
    parameter int          ON_CYCLES       = DEF_ON_CYCLES,
    parameter int          OFF_CYCLES      = DEF_OFF_CYCLES,
    parameter int          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int          PEND_W          = 3,
    parameter int          SCORE_REG       = 30,
    parameter int          LED_N           = 6,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] target,
    input  logic              cpu_we,
    output logic              inj_we,
    output logic [4:0]        inj_rd,
    output logic [31:0]       inj_data,
    input  logic [31:0]       score_in,
    output logic [LED_N-1:0]  score_led,
    output logic              hit_pulse,
    output logic              miss_pulse
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LED_W = (LED_N > 1) ? $clog2(LED_N) : 1;
    localparam logic [31:0]       ON_LAST  = 32'(ON_CYCLES - 1);
    localparam logic [31:0]       OFF_LAST = 32'(OFF_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    function automatic logic [PEND_W-1:0] sat_inc(input logic [PEND_W-1:0] v);
        return (v == PEND_MAX) ? v : v + 1'b1;
    endfunction

    logic [NUM_CH-1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .btn  (btn[gi]),
                .press(press[gi])
            );
        end
    endgenerate

    state_t            state, state_nx;
    logic [31:0]       cnt, cnt_nx;
    // Last lit channel; also the channel the next target must avoid.
    logic [CH_W-1:0]   ch, ch_nx;
    logic [CH_W-1:0]   pick_raw, pick;
    logic [NUM_CH-1:0] target_nx;
    logic [15:0]       lfsr;
    logic [PEND_W-1:0] pending, pending_nx;
    logic              cooldown;
    logic [LED_W-1:0]  led_idx;
    logic [LED_N-1:0]  led_nx;

    // Next channel: LFSR modulo NUM_CH, bumped by one if it repeats the last.
    always_comb begin
        pick_raw = CH_W'(lfsr % 16'(NUM_CH));
        pick     = pick_raw;
        if (pick_raw == ch) begin
            pick = (pick_raw == CH_LAST) ? '0 : pick_raw + 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ch_nx      = ch;
        target_nx  = target;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        case (state)
            ST_OFF: begin
                if (cnt == OFF_LAST) begin
                    state_nx        = ST_ON;
                    cnt_nx          = '0;
                    ch_nx           = pick;
                    target_nx       = '0;
                    target_nx[pick] = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_ON: begin
                // A hit on the lit channel overrides both a timeout and any
                // simultaneous wrong-button press.
                if (press[ch]) begin
                    hit_pulse = 1'b1;
                    state_nx  = ST_OFF;
                    cnt_nx    = '0;
                    target_nx = '0;
                end else begin
                    if ((press & ~target) != '0) begin
                        miss_pulse = 1'b1;
                    end
                    if (cnt == ON_LAST) begin
                        miss_pulse = 1'b1;
                        state_nx   = ST_OFF;
                        cnt_nx     = '0;
                        target_nx  = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx  = ST_OFF;
                cnt_nx    = '0;
                target_nx = '0;
            end
        endcase
    end

    // The cooldown flag forces at least one idle cycle between injections.
    assign inj_we   = !cpu_we && (pending != '0) && !cooldown;
    assign inj_rd   = 5'(SCORE_REG);
    assign inj_data = 32'(pending);

    always_comb begin
        pending_nx = pending;
        if (inj_we) begin
            pending_nx = hit_pulse ? PEND_W'(1) : '0;
        end else if (hit_pulse) begin
            pending_nx = sat_inc(pending);
        end
    end

    always_comb begin
        led_idx         = LED_W'(score_in % 32'(LED_N));
        led_nx          = '0;
        led_nx[led_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_OFF;
            cnt       <= '0;
            ch        <= '0;
            target    <= '0;
            lfsr      <= LFSR_SEED;
            pending   <= '0;
            cooldown  <= 1'b0;
            score_led <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ch        <= ch_nx;
            target    <= target_nx;
            lfsr      <= lfsr_next(lfsr);
            pending   <= pending_nx;
            cooldown  <= inj_we;
            score_led <= led_nx;
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomised bench for mole_game_ctrl with a behavioural game model.
module tb_mole_game_ctrl;

    localparam int NUM_CH = 4;
    localparam int ON_C   = 20;
    localparam int OFF_C  = 10;
    localparam int DEB    = 3;
    localparam int PEND_W = 3;
    localparam int LED_N  = 6;
    localparam int NCYC   = 3000;
    // Raw low step driven in cycle k -> press event seen in cycle k+PRESS_LAT.
    localparam int PRESS_LAT = DEB + 4;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] btn;
    logic [NUM_CH-1:0] target;
    logic              cpu_we;
    logic              inj_we;
    logic [4:0]        inj_rd;
    logic [31:0]       inj_data;
    logic [31:0]       score_in;
    logic [LED_N-1:0]  score_led;
    logic              hit_pulse;
    logic              miss_pulse;

    mole_game_ctrl #(
        .NUM_CH         (NUM_CH),
        .ON_CYCLES      (ON_C),
        .OFF_CYCLES     (OFF_C),
        .DEBOUNCE_CYCLES(DEB),
        .PEND_W         (PEND_W),
        .SCORE_REG      (30),
        .LED_N          (LED_N),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .target    (target),
        .cpu_we    (cpu_we),
        .inj_we    (inj_we),
        .inj_rd    (inj_rd),
        .inj_data  (inj_data),
        .score_in  (score_in),
        .score_led (score_led),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cur_cyc  = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cur_cyc, got, exp);
        end
    endtask

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    // Behavioural model: lit channel (-1 = dark) and cycles left in the phase.
    int               m_lit, m_left, m_prev, m_pend, m_lfsr;
    bit               m_cool;
    logic [LED_N-1:0] m_led;

    int                low_left [NUM_CH];
    int                avail_at [NUM_CH];
    logic [NUM_CH-1:0] press_sched [NCYC + 16];

    initial begin
        logic [NUM_CH-1:0] b, pr, exp_tgt;
        bit                exp_hit, exp_miss, exp_we, phase_b;
        int                r, thr, hold, pick;

        reset    = 1'b1;
        btn      = '1;
        cpu_we   = 1'b0;
        score_in = 32'd0;
        for (int i = 0; i < NCYC + 16; i++) press_sched[i] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            low_left[i] = 0;
            avail_at[i] = 0;
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_target", 32'(target), 32'd0);
        chk("rst_inj_we", 32'(inj_we), 32'd0);
        chk("rst_inj_data", inj_data, 32'd0);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_miss", 32'(miss_pulse), 32'd0);
        chk("rst_led", 32'(score_led), 32'd0);

        @(negedge clk);
        reset  = 1'b0;
        m_lit  = -1;
        m_left = OFF_C;
        m_prev = 0;
        m_pend = 0;
        m_cool = 1'b0;
        m_lfsr = 16'hACE1;
        m_led  = '0;

        for (int c = 0; c < NCYC; c++) begin
            cur_cyc = c;
            phase_b = (c >= 1200 && c < 1700);
            if (c < 60) cpu_we = 1'b0;
            else if (phase_b || c >= NCYC - 40) cpu_we = 1'b1;
            else cpu_we = ($urandom_range(0, 99) < 25);
            score_in = $urandom;

            // Buttons: clean presses (scheduled as events) and short glitches.
            for (int i = 0; i < NUM_CH; i++) begin
                if (low_left[i] > 0) begin
                    b[i] = 1'b0;
                    low_left[i]--;
                end else begin
                    b[i] = 1'b1;
                    if (c >= 60 && c < NCYC - 40 && c >= avail_at[i]) begin
                        r   = $urandom_range(0, 999);
                        thr = (i == m_lit) ? (phase_b ? 150 : 60) : 8;
                        if (r < thr) begin
                            hold        = $urandom_range(5, 8);
                            b[i]        = 1'b0;
                            low_left[i] = hold - 1;
                            avail_at[i] = c + hold + 10;
                            press_sched[c + PRESS_LAT][i] = 1'b1;
                        end else if (r < thr + 10) begin
                            hold        = $urandom_range(1, 2);
                            b[i]        = 1'b0;
                            low_left[i] = hold - 1;
                            avail_at[i] = c + hold + 6;
                        end
                    end
                end
            end
            btn = b;
            #1;

            pr       = press_sched[c];
            exp_tgt  = (m_lit >= 0) ? NUM_CH'(1 << m_lit) : '0;
            exp_hit  = (m_lit >= 0) && pr[m_lit];
            exp_miss = (m_lit >= 0) && !exp_hit && (((pr & ~exp_tgt) != '0) || m_left == 1);
            exp_we   = !cpu_we && (m_pend != 0) && !m_cool;

            chk("target", 32'(target), 32'(exp_tgt));
            chk("hit_pulse", 32'(hit_pulse), 32'(exp_hit));
            chk("miss_pulse", 32'(miss_pulse), 32'(exp_miss));
            chk("inj_we", 32'(inj_we), 32'(exp_we));
            chk("inj_data", inj_data, 32'(m_pend));
            chk("inj_rd", 32'(inj_rd), 32'd30);
            chk("score_led", 32'(score_led), 32'(m_led));

            if (exp_we) m_pend = exp_hit ? 1 : 0;
            else if (exp_hit && m_pend < (1 << PEND_W) - 1) m_pend++;
            m_cool = exp_we;
            m_led  = LED_N'(1 << (score_in % LED_N));

            if (m_lit < 0) begin
                m_left--;
                if (m_left == 0) begin
                    pick = m_lfsr % NUM_CH;
                    if (pick == m_prev) pick = (pick + 1) % NUM_CH;
                    m_prev = pick;
                    m_lit  = pick;
                    m_left = ON_C;
                end
            end else if (exp_hit || m_left == 1) begin
                m_lit  = -1;
                m_left = OFF_C;
            end else begin
                m_left--;
            end
            m_lfsr = lfsr_step(m_lfsr);

            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle clears everything at once.
        cur_cyc = NCYC;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_target", 32'(target), 32'd0);
        chk("mid_rst_inj_we", 32'(inj_we), 32'd0);
        chk("mid_rst_pending", inj_data, 32'd0);
        chk("mid_rst_led", 32'(score_led), 32'd0);

        @(negedge clk);
        reset    = 1'b0;
        cpu_we   = 1'b0;
        score_in = 32'd13;
        @(posedge clk);
        #1;
        chk("led_13", 32'(score_led), 32'b000010);
        chk("post_rst_target", 32'(target), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
